// File: rtl/alu_div_sequencer.sv
// Multi-cycle unsigned divide/remainder sequencer.
// Drives the shared datapath ALU with repeated compare/subtract steps.

package custom_types;
  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_LT  = 2'd2,
    ALU_AND = 2'd3
  } alu_operation_t;
endpackage

module alu_div_sequencer
  import custom_types::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output alu_operation_t   alu_operation,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {IDLE, CMP, SUB, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             dbz_q, dbz_d;

  // The ALU zero flag is not needed: the LT result already encodes the decision.
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      dbz_q   <= dbz_d;
    end
  end

  // NOTE: every signal is given a default first so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    dvs_d         = dvs_q;
    quo_d         = quo_q;
    dbz_d         = dbz_q;
    alu_op1       = '0;
    alu_op2       = '0;
    alu_operation = ALU_ADD;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          rem_d = dividend;
          dvs_d = divisor;
          quo_d = '0;
          if (divisor == '0) begin
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            dbz_d   = 1'b0;
            state_d = CMP;
          end
        end
      end
      CMP: begin
        alu_op1       = rem_q;
        alu_op2       = dvs_q;
        alu_operation = ALU_LT;
        state_d       = alu_result[0] ? DONE : SUB;
      end
      SUB: begin
        alu_op1       = rem_q;
        alu_op2       = dvs_q;
        alu_operation = ALU_SUB;
        // SUB only follows a failed LT, so this never underflows.
        rem_d         = alu_result;
        quo_d         = quo_q + WIDTH'(1);
        state_d       = CMP;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q == CMP) || (state_q == SUB);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Self-checking bench for alu_div_sequencer: behavioural ALU plus an
// arithmetic reference (a/b, a%b, 2q+1 latency) for directed and random runs.

module tb_alu_div_sequencer;
  import custom_types::*;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   dividend, divisor;
  logic           busy, done, div_by_zero;
  logic [W-1:0]   quotient, remainder;
  logic [W-1:0]   alu_op1, alu_op2, alu_result;
  alu_operation_t alu_operation;
  logic           alu_zero;

  int checks   = 0;
  int failures = 0;

  alu_div_sequencer #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .dividend     (dividend),
    .divisor      (divisor),
    .busy         (busy),
    .done         (done),
    .quotient     (quotient),
    .remainder    (remainder),
    .div_by_zero  (div_by_zero),
    .alu_op1      (alu_op1),
    .alu_op2      (alu_op2),
    .alu_operation(alu_operation),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero)
  );

  always #5 clk = ~clk;

  // Behavioural model of the shared ALU.
  always_comb begin
    case (alu_operation)
      ALU_ADD: alu_result = alu_op1 + alu_op2;
      ALU_SUB: alu_result = alu_op1 - alu_op2;
      ALU_LT:  alu_result = (alu_op1 < alu_op2) ? W'(1) : W'(0);
      default: alu_result = alu_op1 & alu_op2;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at the negedge right after the accepting edge; returns the number of
  // cycles until done is seen, plus busy and LT cycles observed along the way.
  task automatic wait_done(output int k, output int busy_n, output int lt_n);
    k = 0; busy_n = 0; lt_n = 0;
    while (done !== 1'b1 && k < 60) begin
      if (busy === 1'b1) busy_n++;
      if (alu_operation == ALU_LT) lt_n++;
      @(posedge clk); @(negedge clk);
      k++;
    end
  endtask

  task automatic run_div(input string name, input int a, input int b);
    int k, busy_n, lt_n, q, r, lat;
    q   = (b == 0) ? 0 : a / b;
    r   = (b == 0) ? a : a % b;
    lat = (b == 0) ? 0 : 2 * q + 1;
    @(negedge clk);
    start = 1'b1; dividend = W'(a); divisor = W'(b);
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    check({name, ".busy0"}, 32'(busy), 32'(b != 0));
    if (b != 0) begin
      check({name, ".op1"}, 32'(alu_op1), 32'(a));
      check({name, ".op2"}, 32'(alu_op2), 32'(b));
    end
    wait_done(k, busy_n, lt_n);
    check({name, ".latency"}, 32'(k), 32'(lat));
    check({name, ".done"}, 32'(done), 32'd1);
    check({name, ".quot"}, 32'(quotient), 32'(q));
    check({name, ".rem"}, 32'(remainder), 32'(r));
    check({name, ".dbz"}, 32'(div_by_zero), 32'(b == 0));
    check({name, ".busy_cycles"}, 32'(busy_n), 32'(lat));
    check({name, ".lt_cycles"}, 32'(lt_n), 32'((b == 0) ? 0 : q + 1));
    @(posedge clk); @(negedge clk);
    check({name, ".done_1cyc"}, 32'(done), 32'd0);
    check({name, ".hold_q"}, 32'(quotient), 32'(q));
    check({name, ".hold_r"}, 32'(remainder), 32'(r));
  endtask

  initial begin
    int k, busy_n, lt_n, a, b;
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.quot", 32'(quotient), 32'd0);
    check("rst.rem", 32'(remainder), 32'd0);
    check("rst.dbz", 32'(div_by_zero), 32'd0);
    check("rst.aluop", 32'(alu_operation), 32'(ALU_ADD));
    check("rst.aluop1", 32'(alu_op1), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_div("d10_5", 10, 5);
    run_div("d5_10", 5, 10);
    run_div("d15_1", 15, 1);
    run_div("d13_4", 13, 4);
    run_div("d7_0", 7, 0);

    // 10/5 with a 9/3 request raised while busy and held through DONE.
    @(negedge clk);
    start = 1'b1; dividend = 4'd10; divisor = 4'd5;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    start = 1'b1; dividend = 4'd9; divisor = 4'd3;
    wait_done(k, busy_n, lt_n);
    check("ign.latency", 32'(k + 1), 32'd5);
    check("ign.quot", 32'(quotient), 32'd2);
    check("ign.rem", 32'(remainder), 32'd0);
    @(posedge clk); @(negedge clk);
    check("ign.idle_busy", 32'(busy), 32'd0);
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    check("held.busy", 32'(busy), 32'd1);
    wait_done(k, busy_n, lt_n);
    check("held.latency", 32'(k), 32'd7);
    check("held.quot", 32'(quotient), 32'd3);
    check("held.rem", 32'(remainder), 32'd0);

    // Reset asserted during the SUB state of 15/1.
    @(negedge clk);
    start = 1'b1; dividend = 4'd15; divisor = 4'd1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    check("abort.in_sub", 32'(alu_operation), 32'(ALU_SUB));
    reset = 1'b1;
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.quot", 32'(quotient), 32'd0);
    check("abort.rem", 32'(remainder), 32'd0);
    check("abort.dbz", 32'(div_by_zero), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("abort.no_done", 32'(done), 32'd0);
    reset = 1'b0;
    run_div("d6_4", 6, 4);

    for (int i = 0; i < 24; i++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      run_div($sformatf("rnd%0d_%0d_%0d", i, a, b), a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_div_sequencer.md
Name: alu_div_sequencer

Overview:
- Multi-cycle controller that computes unsigned 4-bit quotient and remainder by repeated compare/subtract.
- It does not contain an ALU. It drives the operand and operation inputs of the shared `alu` instance (`op1`, `op2`, `operation`, `result`, `zero`) through its `alu_*` ports.
- Sits beside the datapath ALU as the sequencer for DIV/REM instructions.
- Uses `ALU_LT` and `ALU_SUB` from `custom_types::alu_operation_t`.

Parameters:
- WIDTH, 4, data width; must equal the `alu` data width (4).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- dividend  input  WIDTH  unsigned dividend; captured on the accepting edge.
- divisor  input  WIDTH  unsigned divisor; captured on the accepting edge.
- busy  output  1  high in CMP and SUB states.
- done  output  1  single-cycle completion strobe; high in DONE state.
- quotient  output  WIDTH  registered quotient; valid from done, held until the next accepted start.
- remainder  output  WIDTH  registered remainder; same validity as quotient.
- div_by_zero  output  1  registered error flag; valid with done.
- alu_op1  output  WIDTH  drives `alu.op1`.
- alu_op2  output  WIDTH  drives `alu.op2`.
- alu_operation  output  alu_operation_t  drives `alu.operation`.
- alu_result  input  WIDTH  from `alu.result`.
- alu_zero  input  1  from `alu.zero`; unused by the FSM, kept for interface completeness.

Behaviour:
- Reset (asynchronous, any state) gives:
  - state = IDLE;
  - busy = 0, done = 0, div_by_zero = 0;
  - quotient = 0, remainder = 0;
  - internal divisor register = 0.
- ALU contract: `ALU_LT` returns 1 (LSB = 1) when op1 < op2 unsigned, otherwise 0. `ALU_SUB` returns op1 − op2 modulo 2^WIDTH.
- ALU drive is combinational from state:
  - CMP: op1 = remainder reg, op2 = divisor reg, operation = `ALU_LT`.
  - SUB: same operands, operation = `ALU_SUB`.
  - IDLE and DONE: op1 = op2 = 0, operation = `ALU_ADD`.
- FSM states: IDLE, CMP, SUB, DONE.
- IDLE:
  - If start = 1, load remainder ← dividend, divisor reg ← divisor, quotient ← 0, div_by_zero ← 0.
  - If divisor == 0: set div_by_zero ← 1 and go to DONE. quotient stays 0, remainder = dividend.
  - Otherwise go to CMP.
  - If start = 0, stay in IDLE; outputs hold.
- CMP:
  - If alu_result[0] = 1 (remainder < divisor), go to DONE.
  - Otherwise go to SUB.
- SUB: remainder ← alu_result, quotient ← quotient + 1, go to CMP.
- DONE: done = 1 for exactly one cycle, then go to IDLE unconditionally.
- start handling:
  - start is ignored in CMP, SUB and DONE; requests are not queued.
  - A start held high through DONE is accepted on the first IDLE cycle.
- Latency: edge E accepts start. With q the true quotient, done is high in the cycle after edge E + 2q + 1. For divisor = 0, done is high in the cycle after E.
- Arithmetic bounds: quotient ≤ 15 (reached for 15/1), so the 4-bit counter cannot wrap. The remainder never underflows because SUB only follows a failed LT.
- Reset mid-operation aborts immediately. The partial result is discarded and done is not asserted.

Test Plan:
- dividend = 10, divisor = 5, start pulse → busy high; done in the cycle after edge E+5; quotient = 2, remainder = 0, div_by_zero = 0.
- dividend = 5, divisor = 10 → done after E+1; quotient = 0, remainder = 5; exactly one `ALU_LT` cycle is seen on alu_operation.
- dividend = 15, divisor = 1 → done after E+31; quotient = 15, remainder = 0, with no wrap. Also dividend = 13, divisor = 4 → quotient = 3, remainder = 1 after E+7.
- dividend = 7, divisor = 0 → done in the cycle after E; div_by_zero = 1, quotient = 0, remainder = 7; busy never asserted.
- During the 10/5 run, pulse start with 9/3 while busy → ignored; the result is still 2 rem 0. Holding start high through DONE → 9/3 is accepted next, giving 3 rem 0.
- Assert reset during SUB of 15/1 → all outputs 0 and state IDLE immediately, with no done pulse. A new 6/4 run after reset → quotient = 1, remainder = 2.
